// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and FSM state type for the multiplier arbiter
package mul_pkg;

    localparam int NREQ = 2;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with explicit pointer advance
module rr_arbiter2
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic            adv_idx,
    output logic [NREQ-1:0] grant
);

    logic ptr;
    logic other;

    assign other = ~ptr;

    // Favour the pointed-to requester; fall back to the other so a lone requester always wins
    always_comb begin
        grant = '0;
        if (req[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (req[other]) begin
            grant[other] = 1'b1;
        end
    end

    // Move priority past the requester whose response just completed
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~adv_idx;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one multiplier between two requesters, one op in flight
module mul_arbiter
    import mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_rs1,
    input  logic [NREQ-1:0][31:0] req_rs2,
    input  logic [NREQ-1:0][2:0]  req_funct3,
    input  logic [NREQ-1:0][4:0]  req_rd,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [4:0]            rsp_rd,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [31:0]           mul_rs1,
    output logic [31:0]           mul_rs2,
    output logic [2:0]            mul_funct3,
    input  logic [31:0]           mul_result,
    input  logic                  mul_done
);

    state_t      state;
    logic        grant_idx;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic        err_q;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] grant;
    logic            sel;
    logic            accept;
    logic            rsp_fire;

    // Requests are only visible to the arbiter while idle and out of reset
    assign arb_req  = (state == ST_IDLE && !reset) ? req_valid : '0;
    assign sel      = grant[1];
    assign accept   = |grant;
    assign rsp_fire = (state == ST_RESP) && rsp_ready[grant_idx];

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .adv     (rsp_fire),
        .adv_idx (grant_idx),
        .grant   (grant)
    );

    assign req_ready  = grant;
    assign rsp_valid  = (state == ST_RESP) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_rd     = rd_q;
    assign rsp_err    = err_q;
    assign mul_start  = (state == ST_ISSUE);
    assign mul_rs1    = rs1_q;
    assign mul_rs2    = rs2_q;
    assign mul_funct3 = funct3_q;

    // Op sequencing: accept, issue, wait for the multiplier, hold the response until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant_idx <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_idx <= sel;
                        rs1_q     <= req_rs1[sel];
                        rs2_q     <= req_rs2[sel];
                        funct3_q  <= req_funct3[sel];
                        rd_q      <= req_rd[sel];
                        result_q  <= '0;
                        if (req_funct3[sel][2]) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        result_q <= mul_result;
                        err_q    <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter with a fixed-latency multiplier
module tb_mul_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_rs1;
    logic [1:0][31:0] req_rs2;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][4:0]  req_rd;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_rd;
    logic             rsp_err;
    logic             mul_start;
    logic [31:0]      mul_rs1;
    logic [31:0]      mul_rs2;
    logic [2:0]       mul_funct3;
    logic [31:0]      mul_result;
    logic             mul_done;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int exp_ptr = 0;

    always #5 clk = ~clk;

    mul_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_rs1    (mul_rs1),
        .mul_rs2    (mul_rs2),
        .mul_funct3 (mul_funct3),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    // Reference product: full 64-bit product modulo 2^64, then pick the half the op asks for
    function automatic logic [31:0] mul_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        if (f3[2])          return 32'h0;
        else if (f3 == 3'b000) return p[31:0];
        else                return p[63:32];
    endfunction

    // Stand-in multiplier: done two edges after the start edge, level until the next start
    logic [1:0] mcnt;
    logic [31:0] mres;
    always @(posedge clk) begin
        if (reset) begin
            mcnt <= 2'd0; mul_done <= 1'b0; mul_result <= 32'h0; mres <= 32'h0;
        end else if (mul_start) begin
            mcnt <= 2'd2; mul_done <= 1'b0; mres <= mul_ref(mul_funct3, mul_rs1, mul_rs2);
        end else if (mcnt != 2'd0) begin
            mcnt <= mcnt - 2'd1;
            if (mcnt == 2'd1) begin
                mul_done <= 1'b1; mul_result <= mres;
            end
        end
    end

    always @(posedge clk) if (mul_start) start_cnt = start_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction from a single requester, with latency and stall checks
    task automatic do_op(input int idx, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expr, input logic expe, input int hold);
        int n;
        int s0;
        logic [1:0] oh;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req_rs1[idx] = a; req_rs2[idx] = b; req_funct3[idx] = f3; req_rd[idx] = rd;
        req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 50) begin @(negedge clk); #1; n++; end
        check("grant_timeout", 32'(n < 50), 32'd1);
        check("req_ready_onehot", 32'(req_ready), 32'(oh));
        s0 = start_cnt;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        n = 1;
        while (!rsp_valid[idx] && n < 50) begin @(negedge clk); #1; n++; end
        check("rsp_latency", n, expe ? 1 : 5);
        check("rsp_valid", 32'(rsp_valid), 32'(oh));
        check("rsp_result", rsp_result, expr);
        check("rsp_err", 32'(rsp_err), 32'(expe));
        check("rsp_rd", 32'(rsp_rd), 32'(rd));
        check("mul_start_count", start_cnt - s0, expe ? 0 : 1);
        rsp_ready = ~oh;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'(oh));
            check("hold_result", rsp_result, expr);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = oh;
        @(negedge clk); #1;
        rsp_ready = 2'b00;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        exp_ptr = 1 - idx;
    endtask

    typedef struct {
        int          idx;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int g;
        int cnt[2];
        logic [4:0] tag;
        logic [2:0] rf3;
        logic [31:0] ra, rb;

        vecs[0] = '{0, 3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0, 0};
        vecs[1] = '{1, 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE, 1'b0, 0};
        vecs[2] = '{1, 3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd10, 32'h00000000, 1'b0, 10};
        vecs[3] = '{0, 3'b100, 32'd123,        32'd456,      5'd3,  32'h00000000, 1'b1, 2};
        vecs[4] = '{0, 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF, 1'b0, 0};
        vecs[5] = '{1, 3'b111, 32'd1,          32'd2,        5'd31, 32'h00000000, 1'b1, 0};
        vecs[6] = '{0, 3'b000, 32'h00010000,   32'h00010000, 5'd1,  32'h00000000, 1'b0, 1};
        vecs[7] = '{1, 3'b011, 32'h80000000,   32'd4,        5'd2,  32'h00000002, 1'b0, 0};

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_rd = '0;
        repeat (3) @(negedge clk);
        req_valid = 2'b11; #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mul_start", 32'(mul_start), 32'd0);
        check("reset_result", rsp_result, 32'd0);
        req_valid = 2'b00;
        @(negedge clk); reset = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].idx, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].err, vecs[i].hold);

        // Both requesters continuously valid: strict alternation, tags follow the issuer
        cnt[0] = 0; cnt[1] = 0;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            req_rs1[r] = 32'd1; req_rs2[r] = 32'(r + 2); req_funct3[r] = 3'b000; req_rd[r] = 5'(r * 16);
        end
        req_valid = 2'b11; rsp_ready = 2'b11; #1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!(|req_ready) && n < 30) begin @(negedge clk); #1; n++; end
            check("alt_timeout", 32'(n < 30), 32'd1);
            g = req_ready[1] ? 1 : 0;
            check("alt_grant", g, exp_ptr);
            tag = req_rd[g];
            ra = req_rs1[g]; rb = req_rs2[g];
            @(negedge clk);
            cnt[g]++;
            req_rs1[g] = 32'(cnt[g] + 1); req_rd[g] = 5'(g * 16 + cnt[g]);
            if (cnt[g] == 4) req_valid[g] = 1'b0;
            #1;
            n = 1;
            while (!rsp_valid[g] && n < 30) begin @(negedge clk); #1; n++; end
            check("alt_rsp_rd", 32'(rsp_rd), 32'(tag));
            check("alt_rsp_result", rsp_result, ra * rb);
            exp_ptr = 1 - g;
            @(negedge clk); #1;
        end
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Reset in the middle of WAIT discards the op and clears every output
        @(negedge clk);
        req_rs1[0] = 32'd9; req_rs2[0] = 32'd9; req_funct3[0] = 3'b000; req_rd[0] = 5'd7;
        req_valid[0] = 1'b1; #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk); req_valid[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_ops", {mul_rs1[15:0], mul_rs2[7:0], 5'd0, mul_funct3}, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0; exp_ptr = 0;
        do_op(1, 3'b000, 32'd6, 32'd7, 5'd12, 32'd42, 1'b0, 0);

        // Randomised ops against the reference product
        for (int k = 0; k < 20; k++) begin
            g = $urandom % 2;
            rf3 = 3'($urandom % 8);
            ra = $urandom; rb = $urandom;
            do_op(g, rf3, ra, rb, 5'($urandom), mul_ref(rf3, ra, rb), rf3[2], $urandom % 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; both ports are listed below.
REQ-002 SHALL have ports as follows (name / direction / width / meaning):
- clk / in / 1 / clock, all state on posedge.
- reset / in / 1 / synchronous active-high reset.
- req_valid / in / 2 / per-requester request valid.
- req_ready / out / 2 / per-requester accept; at most one bit high.
- req_rs1, req_rs2 / in / 2x32 / per-requester operands.
- req_funct3 / in / 2x3 / per-requester op select.
- req_rd / in / 2x5 / per-requester destination tag.
- rsp_valid / out / 2 / per-requester response valid; at most one bit high.
- rsp_ready / in / 2 / per-requester response accept.
- rsp_result / out / 32 / result for the granted requester.
- rsp_rd / out / 5 / echoed tag.
- rsp_err / out / 1 / unsupported op.
- mul_start / out / 1 / multiplier start pulse.
- mul_rs1, mul_rs2 / out / 32 / multiplier operands.
- mul_funct3 / out / 3 / multiplier op.
- mul_result / in / 32 / multiplier result.
- mul_done / in / 1 / multiplier done, level.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE with any req_valid high, SHALL combinationally raise req_ready for exactly one requester, chosen round-robin.
- Priority pointer favours the requester not most recently served.
- A lone valid requester is always granted.
REQ-005 On the edge where req_valid&req_ready, SHALL register rs1, rs2, funct3 and rd, and record the grant index.
- If funct3[2]==0: go to ISSUE.
- Otherwise: go to RESP with result 0 and rsp_err=1; mul_start is never raised.
REQ-006 In ISSUE, SHALL drive mul_start=1 for exactly one cycle, then go to WAIT; mul_start SHALL be 0 in every other state.
REQ-007 mul_rs1, mul_rs2 and mul_funct3 SHALL be registered and held stable from ISSUE through the WAIT-exit edge.
REQ-008 In WAIT, mul_done==1 SHALL capture mul_result into rsp_result with rsp_err=0, then go to RESP.
- mul_done is low during the first WAIT cycle, so stale done from the previous op is not a hazard.
REQ-009 Latency SHALL be fixed, with acceptance edge = E0:
- rsp_valid rises in the cycle after E4.
- Error ops: rsp_valid rises in the cycle after E0.
REQ-010 In RESP, SHALL hold rsp_valid[grant]=1 and rsp_result/rsp_rd/rsp_err stable until rsp_ready[grant]==1.
- On that edge: return to IDLE and advance the round-robin pointer past the served requester.
REQ-011 req_ready SHALL be 0 in ISSUE, WAIT and RESP; no new request is accepted in the same cycle a response completes (one op in flight).
REQ-012 rsp_ready of the non-granted requester SHALL be ignored.
REQ-013 Simultaneous valid on both requesters SHALL produce strict alternation under continuous load.

Reset
REQ-014 Reset SHALL force, at any point including mid-WAIT: state=IDLE, round-robin pointer=0 (requester 0 first), all outputs 0 (req_ready, rsp_valid, rsp_result, rsp_rd, rsp_err, mul_start, mul_rs1, mul_rs2, mul_funct3).
REQ-015 An op in flight at reset SHALL be discarded with no response; the multiplier is reset by the same signal.

Structure
REQ-016 A shared package mul_pkg SHALL hold:
- funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011;
- the FSM state enum;
- requester count NREQ=2.
REQ-017 Round-robin grant logic SHALL be a separate sub-module rr_arbiter2 (request vector, pointer-advance strobe, one-hot grant); mul_arbiter does not instantiate the multiplier.

Verification
REQ-018 The bench SHALL pair mul_arbiter with the existing multiplier and cover at least these scenarios:
- Req0 MUL 7 x 0xFFFFFFFD -> rsp_valid[0] in the cycle after E4, rsp_result=0xFFFFFFEB, rsp_err=0, one-cycle mul_start.
- Req1 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rsp_result=0xFFFFFFFE; req1 MULH same operands -> 0x00000000.
- Both requesters valid continuously for 4 ops each -> grants 0,1,0,1,...; rsp_rd matches each issuer's tag.
- rsp_ready held low 10 cycles in RESP -> rsp_valid/rsp_result stable; req_ready stays 0; proceeds on rsp_ready.
- funct3=100 from req0 -> rsp_err=1, result 0 in the cycle after E0, mul_start never asserted.
- Reset asserted during WAIT -> all outputs 0 next cycle; a following req1 request is granted and completes correctly.
